// File: rtl/udp_rx_pkg.sv
// Shared definitions for the UDP receive port demultiplexer.
//   UDP_HDR_BYTES : number of bytes in a UDP header
//   UDP_HDR_LEN   : same value as a 16-bit quantity for length arithmetic
//   udp_state_t   : demux FSM states
//   udp_port_t    : 16-bit UDP port number
package udp_rx_pkg;

    localparam int          UDP_HDR_BYTES = 8;
    localparam logic [15:0] UDP_HDR_LEN   = 16'd8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR      = 3'd1,
        ST_MATCH    = 3'd2,
        ST_HDR_EMIT = 3'd3,
        ST_PAYLOAD  = 3'd4,
        ST_DROP     = 3'd5
    } udp_state_t;

    typedef logic [15:0] udp_port_t;

endpackage

// File: rtl/udp_port_fifo.sv
// First-word-fall-through FIFO holding {last, byte} entries for one output port.
//   clk, rst_n : clock and asynchronous active-low reset
//   wr_en/wr_data : push one 9-bit entry
//   rd_en      : pop the head entry (ignored when empty)
//   rd_data    : head entry, valid while rd_vld is high
//   free_cnt   : number of unused entries
module udp_port_fifo
#(
    parameter int DEPTH = 2048
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [8:0]              wr_data,
    input  logic                    rd_en,
    output logic [8:0]              rd_data,
    output logic                    rd_vld,
    output logic [$clog2(DEPTH):0]  free_cnt
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [8:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_s;
    logic          pop_s;

    assign pop_s    = rd_en & (count_r != {(AW + 1){1'b0}});
    // A write into a full FIFO is accepted when the same cycle pops an entry.
    assign push_s   = wr_en & ((count_r != FULL_CNT) | pop_s);
    assign rd_data  = mem_r[rd_ptr_r];
    assign rd_vld   = (count_r != {(AW + 1){1'b0}});
    assign free_cnt = FULL_CNT - count_r;

    // Storage array; contents are qualified by count so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/udp_rx_port_demux.sv
// Routes received UDP datagrams to per-destination-port output FIFOs.
//   i_rxmac_clk / i_rxmac_arst_n : clock, asynchronous active-low reset
//   i_udp_pkt_*  / o_udp_pkt_byte_rd : byte stream in, consumed on vld & rd
//   i_port_tbl / i_port_en       : destination port per output and its enable
//   o_port_* / i_port_byte_rd    : FWFT output streams, one per port
//   o_port_drop_cnt              : saturating per-port count of datagrams dropped for space
//   o_unsupported_dest_port, o_udp_len_error : one-cycle event pulses
module udp_rx_port_demux
    import udp_rx_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int PORT_FIFO_DEPTH = 2048,
    parameter int STRIP_HDR       = 1
) (
    input  logic                       i_rxmac_clk,
    input  logic                       i_rxmac_arst_n,
    input  logic [7:0]                 i_udp_pkt_byte,
    input  logic                       i_udp_pkt_byte_vld,
    input  logic                       i_udp_pkt_last_byte,
    output logic                       o_udp_pkt_byte_rd,
    input  logic [NUM_PORTS-1:0][15:0] i_port_tbl,
    input  logic [NUM_PORTS-1:0]       i_port_en,
    output logic [NUM_PORTS-1:0][7:0]  o_port_byte,
    output logic [NUM_PORTS-1:0]       o_port_byte_vld,
    output logic [NUM_PORTS-1:0]       o_port_last_byte,
    input  logic [NUM_PORTS-1:0]       i_port_byte_rd,
    output logic [NUM_PORTS-1:0][15:0] o_port_drop_cnt,
    output logic                       o_unsupported_dest_port,
    output logic                       o_udp_len_error
);
    localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int FREE_W = $clog2(PORT_FIFO_DEPTH) + 1;

    udp_state_t                          state_r, state_s;
    logic [UDP_HDR_BYTES-1:0][7:0]       hdr_r;
    logic [2:0]                          cnt_r, cnt_s, hdr_idx_s;
    logic                                hdr_last_r, hdr_last_s;
    logic [15:0]                         rem_r, rem_s;
    logic [IDX_W-1:0]                    tgt_r, tgt_s;
    logic                                rst_done_r;
    logic                                unsup_r, unsup_s, len_err_r, len_err_s;
    logic [NUM_PORTS-1:0][15:0]          drop_cnt_r;
    logic                                drop_inc_s, rd_s, accept_s, hdr_wr_s, wr_s;
    logic [8:0]                          wr_data_s;
    udp_port_t                           dest_s;
    logic [15:0]                         len_s, need_s;
    logic                                hit_s;
    logic [IDX_W-1:0]                    hit_idx_s;
    logic [NUM_PORTS-1:0][FREE_W-1:0]    free_s;
    logic [NUM_PORTS-1:0][8:0]           fifo_rd_data_s;
    logic [NUM_PORTS-1:0]                fifo_vld_s;
    logic [16:0]                         tgt_free_s;

    assign dest_s     = {hdr_r[2], hdr_r[3]};
    assign len_s      = {hdr_r[4], hdr_r[5]};
    assign need_s     = (STRIP_HDR != 0) ? (len_s - UDP_HDR_LEN) : len_s;
    assign tgt_free_s = 17'(free_s[hit_idx_s]);
    assign accept_s   = i_udp_pkt_byte_vld & rd_s;
    assign hdr_idx_s  = (state_r == ST_HDR) ? cnt_r : 3'd0;

    assign o_udp_pkt_byte_rd       = rd_s;
    assign o_unsupported_dest_port = unsup_r;
    assign o_udp_len_error         = len_err_r;
    assign o_port_drop_cnt         = drop_cnt_r;

    // Input handshake: stalled while matching, emitting the header, or held in reset.
    always_comb begin
        rd_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_HDR, ST_PAYLOAD, ST_DROP: rd_s = rst_done_r;
            default:                              rd_s = 1'b0;
        endcase
    end

    // Destination lookup: scanning from the top leaves the lowest matching index.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = {IDX_W{1'b0}};
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (i_port_en[i] && (i_port_tbl[i] == dest_s)) begin
                hit_s     = 1'b1;
                hit_idx_s = IDX_W'(i);
            end else begin
                hit_idx_s = hit_idx_s;
            end
        end
    end

    // FSM next-state, FIFO write and event-pulse decode.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        hdr_last_s = hdr_last_r;
        rem_s      = rem_r;
        tgt_s      = tgt_r;
        unsup_s    = 1'b0;
        len_err_s  = 1'b0;
        drop_inc_s = 1'b0;
        hdr_wr_s   = 1'b0;
        wr_s       = 1'b0;
        wr_data_s  = 9'd0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = 3'd0;
                if (accept_s) begin
                    hdr_wr_s = 1'b1;
                    cnt_s    = 3'd1;
                    if (i_udp_pkt_last_byte) begin
                        len_err_s = 1'b1;
                    end else begin
                        state_s = ST_HDR;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (accept_s) begin
                    hdr_wr_s = 1'b1;
                    if (cnt_r == 3'd7) begin
                        // Last on byte 7 is legal only for an 8-byte datagram; MATCH decides.
                        hdr_last_s = i_udp_pkt_last_byte;
                        state_s    = ST_MATCH;
                    end else if (i_udp_pkt_last_byte) begin
                        len_err_s = 1'b1;
                        state_s   = ST_IDLE;
                    end else begin
                        cnt_s = cnt_r + 3'd1;
                    end
                end else begin
                    state_s = ST_HDR;
                end
            end
            ST_MATCH: begin
                cnt_s = 3'd0;
                rem_s = len_s - UDP_HDR_LEN;
                tgt_s = hit_idx_s;
                if ((len_s < UDP_HDR_LEN) || (hdr_last_r && (len_s != UDP_HDR_LEN))) begin
                    len_err_s = 1'b1;
                    state_s   = hdr_last_r ? ST_IDLE : ST_DROP;
                end else if (!hit_s) begin
                    unsup_s = 1'b1;
                    state_s = hdr_last_r ? ST_IDLE : ST_DROP;
                end else if (tgt_free_s < {1'b0, need_s}) begin
                    drop_inc_s = 1'b1;
                    state_s    = hdr_last_r ? ST_IDLE : ST_DROP;
                end else if (STRIP_HDR == 0) begin
                    state_s = ST_HDR_EMIT;
                end else if (len_s == UDP_HDR_LEN) begin
                    // Zero payload: nothing to write; a missing last is a length mismatch.
                    len_err_s = ~hdr_last_r;
                    state_s   = hdr_last_r ? ST_IDLE : ST_DROP;
                end else begin
                    state_s = ST_PAYLOAD;
                end
            end
            ST_HDR_EMIT: begin
                wr_s      = 1'b1;
                wr_data_s = {(cnt_r == 3'd7) && (rem_r == 16'd0), hdr_r[cnt_r]};
                if (cnt_r == 3'd7) begin
                    cnt_s = 3'd0;
                    if (rem_r != 16'd0) begin
                        state_s = ST_PAYLOAD;
                    end else if (hdr_last_r) begin
                        state_s = ST_IDLE;
                    end else begin
                        len_err_s = 1'b1;
                        state_s   = ST_DROP;
                    end
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end
            ST_PAYLOAD: begin
                if (accept_s) begin
                    wr_s      = 1'b1;
                    wr_data_s = {i_udp_pkt_last_byte | (rem_r == 16'd1), i_udp_pkt_byte};
                    rem_s     = rem_r - 16'd1;
                    if (i_udp_pkt_last_byte) begin
                        len_err_s = (rem_r != 16'd1);
                        state_s   = ST_IDLE;
                    end else if (rem_r == 16'd1) begin
                        // Length exhausted without last: close the entry, discard the tail.
                        len_err_s = 1'b1;
                        state_s   = ST_DROP;
                    end else begin
                        state_s = ST_PAYLOAD;
                    end
                end else begin
                    state_s = ST_PAYLOAD;
                end
            end
            ST_DROP: begin
                if (accept_s && i_udp_pkt_last_byte) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, datagram bookkeeping and registered event pulses.
    always_ff @(posedge i_rxmac_clk or negedge i_rxmac_arst_n) begin
        if (!i_rxmac_arst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 3'd0;
            hdr_last_r <= 1'b0;
            rem_r      <= 16'd0;
            tgt_r      <= {IDX_W{1'b0}};
            rst_done_r <= 1'b0;
            unsup_r    <= 1'b0;
            len_err_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            hdr_last_r <= hdr_last_s;
            rem_r      <= rem_s;
            tgt_r      <= tgt_s;
            rst_done_r <= 1'b1;
            unsup_r    <= unsup_s;
            len_err_r  <= len_err_s;
        end
    end

    // Header byte capture.
    always_ff @(posedge i_rxmac_clk or negedge i_rxmac_arst_n) begin
        if (!i_rxmac_arst_n) begin
            hdr_r <= '0;
        end else if (hdr_wr_s) begin
            hdr_r[hdr_idx_s] <= i_udp_pkt_byte;
        end
    end

    // Saturating per-port drop counters.
    always_ff @(posedge i_rxmac_clk or negedge i_rxmac_arst_n) begin
        if (!i_rxmac_arst_n) begin
            drop_cnt_r <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (drop_inc_s && (hit_idx_s == IDX_W'(i)) && (drop_cnt_r[i] != 16'hFFFF)) begin
                    drop_cnt_r[i] <= drop_cnt_r[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        udp_port_fifo #(
            .DEPTH (PORT_FIFO_DEPTH)
        ) u_fifo (
            .clk      (i_rxmac_clk),
            .rst_n    (i_rxmac_arst_n),
            .wr_en    (wr_s && (tgt_r == IDX_W'(g))),
            .wr_data  (wr_data_s),
            .rd_en    (i_port_byte_rd[g]),
            .rd_data  (fifo_rd_data_s[g]),
            .rd_vld   (fifo_vld_s[g]),
            .free_cnt (free_s[g])
        );
        // Mask with valid so stale storage never shows on the outputs.
        assign o_port_byte[g]      = fifo_rd_data_s[g][7:0] & {8{fifo_vld_s[g]}};
        assign o_port_last_byte[g] = fifo_rd_data_s[g][8] & fifo_vld_s[g];
        assign o_port_byte_vld[g]  = fifo_vld_s[g];
    end

endmodule

// File: tb/tb_udp_rx_port_demux.sv
module tb_udp_rx_port_demux;
    localparam int NP    = 4;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [3:0][15:0] tbl;
    logic [3:0]       en;

    logic [7:0]       a_byte, b_byte;
    logic             a_vld, a_last, a_rd, b_vld, b_last, b_rd;
    logic [3:0][7:0]  a_pbyte, b_pbyte;
    logic [3:0]       a_pvld, a_plast, a_prd, b_pvld, b_plast, b_prd;
    logic [3:0][15:0] a_drop, b_drop;
    logic             a_unsup, a_lerr, b_unsup, b_lerr;

    udp_rx_port_demux #(.NUM_PORTS(NP), .PORT_FIFO_DEPTH(DEPTH), .STRIP_HDR(1)) dut_a (
        .i_rxmac_clk(clk), .i_rxmac_arst_n(rst_n),
        .i_udp_pkt_byte(a_byte), .i_udp_pkt_byte_vld(a_vld), .i_udp_pkt_last_byte(a_last),
        .o_udp_pkt_byte_rd(a_rd), .i_port_tbl(tbl), .i_port_en(en),
        .o_port_byte(a_pbyte), .o_port_byte_vld(a_pvld), .o_port_last_byte(a_plast),
        .i_port_byte_rd(a_prd), .o_port_drop_cnt(a_drop),
        .o_unsupported_dest_port(a_unsup), .o_udp_len_error(a_lerr));

    udp_rx_port_demux #(.NUM_PORTS(NP), .PORT_FIFO_DEPTH(DEPTH), .STRIP_HDR(0)) dut_b (
        .i_rxmac_clk(clk), .i_rxmac_arst_n(rst_n),
        .i_udp_pkt_byte(b_byte), .i_udp_pkt_byte_vld(b_vld), .i_udp_pkt_last_byte(b_last),
        .o_udp_pkt_byte_rd(b_rd), .i_port_tbl(tbl), .i_port_en(en),
        .o_port_byte(b_pbyte), .o_port_byte_vld(b_pvld), .o_port_last_byte(b_plast),
        .i_port_byte_rd(b_prd), .o_port_drop_cnt(b_drop),
        .o_unsupported_dest_port(b_unsup), .o_udp_len_error(b_lerr));

    int vectors = 0;
    int miscompares = 0;
    int unsup_a = 0, lerr_a = 0, lerr_b = 0;
    int stall_a = 0, stall_b = 0;
    int u0, l0;
    bit timeout_flag = 1'b0;
    logic [7:0] dg [128];
    logic [8:0] q_a [NP][$];
    logic [8:0] q_b [NP][$];

    // Output monitor: records every popped entry and counts pulse cycles.
    always @(negedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (a_pvld[i] && a_prd[i]) q_a[i].push_back({a_plast[i], a_pbyte[i]});
            if (b_pvld[i] && b_prd[i]) q_b[i].push_back({b_plast[i], b_pbyte[i]});
        end
        if (a_unsup) unsup_a++;
        if (a_lerr)  lerr_a++;
        if (b_lerr)  lerr_b++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NP; i++) begin
            q_a[i].delete();
            q_b[i].delete();
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b, input logic last);
        int guard;
        guard = 0;
        @(negedge clk);
        if (sel) begin b_byte = b; b_vld = 1'b1; b_last = last; end
        else     begin a_byte = b; a_vld = 1'b1; a_last = last; end
        while (((sel ? b_rd : a_rd) !== 1'b1) && (guard < 200)) begin
            if (sel) stall_b++; else stall_a++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) timeout_flag = 1'b1;
        @(posedge clk);
        #1;
        if (sel) begin b_vld = 1'b0; b_last = 1'b0; end
        else     begin a_vld = 1'b0; a_last = 1'b0; end
    endtask

    // Datagram: src 0x1234, dst, length field, zero checksum, payload k*7+3.
    task automatic send_dgram(input bit sel, input logic [15:0] dst, input logic [15:0] len,
                              input int nbytes, input bit with_last);
        dg[0] = 8'h12; dg[1] = 8'h34;
        dg[2] = dst[15:8]; dg[3] = dst[7:0];
        dg[4] = len[15:8]; dg[5] = len[7:0];
        dg[6] = 8'h00; dg[7] = 8'h00;
        for (int k = 8; k < 128; k++) dg[k] = 8'(k * 7 + 3);
        for (int k = 0; k < nbytes; k++) send_byte(sel, dg[k], with_last && (k == nbytes - 1));
        check("tx_timeout", {31'd0, timeout_flag}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        tbl[0] = 16'd30000; tbl[1] = 16'd20000; tbl[2] = 16'd10000; tbl[3] = 16'd20000;
        en = 4'b1111;
        a_byte = 8'h00; a_vld = 1'b0; a_last = 1'b0; a_prd = 4'b1111;
        b_byte = 8'h00; b_vld = 1'b0; b_last = 1'b0; b_prd = 4'b1111;

        // Reset state
        wait_cycles(3);
        check("rst_rd_a",   {31'd0, a_rd}, 32'd0);
        check("rst_rd_b",   {31'd0, b_rd}, 32'd0);
        check("rst_vld_a",  {28'd0, a_pvld}, 32'd0);
        check("rst_drop_a", a_drop[0], 32'd0);
        rst_n = 1'b1;
        wait_cycles(2);
        check("rd_after_rst", {31'd0, a_rd}, 32'd1);

        // len 72 to 20000: ports 1 and 3 both match, lowest index (1) wins
        stall_a = 0; l0 = lerr_a;
        send_dgram(1'b0, 16'd20000, 16'd72, 72, 1'b1);
        wait_cycles(10);
        check("p1_count", q_a[1].size(), 32'd64);
        for (int k = 0; k < 64; k++)
            check("p1_entry", {23'd0, q_a[1][k]}, {23'd0, (k == 63), dg[8 + k]});
        check("p0_empty", q_a[0].size(), 32'd0);
        check("p2_empty", q_a[2].size(), 32'd0);
        check("p3_empty", q_a[3].size(), 32'd0);
        check("match_stall", stall_a, 32'd1);
        check("no_lerr", lerr_a - l0, 32'd0);
        clear_queues();

        // Unknown destination, then a normal datagram to port 2
        u0 = unsup_a;
        send_dgram(1'b0, 16'd40000, 16'd20, 20, 1'b1);
        wait_cycles(4);
        check("unsup_pulse", unsup_a - u0, 32'd1);
        check("unsup_nowr", q_a[0].size() + q_a[1].size() + q_a[2].size() + q_a[3].size(), 32'd0);
        check("unsup_vld", {28'd0, a_pvld}, 32'd0);
        send_dgram(1'b0, 16'd10000, 16'd12, 12, 1'b1);
        wait_cycles(6);
        check("p2_after_unsup", q_a[2].size(), 32'd4);
        check("p2_last", {31'd0, q_a[2][3][8]}, 32'd1);
        check("p2_b0", {24'd0, q_a[2][0][7:0]}, {24'd0, dg[8]});
        clear_queues();

        // Port 0 filled to DEPTH-10, 20-byte payload then dropped
        @(posedge clk); #1 a_prd[0] = 1'b0;
        send_dgram(1'b0, 16'd30000, 16'd62, 62, 1'b1);
        wait_cycles(4);
        check("fill_vld", {31'd0, a_pvld[0]}, 32'd1);
        check("fill_nopop", q_a[0].size(), 32'd0);
        send_dgram(1'b0, 16'd30000, 16'd28, 28, 1'b1);
        wait_cycles(4);
        check("drop_cnt0", a_drop[0], 32'd1);
        check("drop_cnt1", a_drop[1], 32'd0);
        a_prd[0] = 1'b1;
        wait_cycles(70);
        check("drain_count", q_a[0].size(), 32'd54);
        check("drain_last", {31'd0, q_a[0][53][8]}, 32'd1);
        clear_queues();
        send_dgram(1'b0, 16'd30000, 16'd28, 28, 1'b1);
        wait_cycles(25);
        check("redo_count", q_a[0].size(), 32'd20);
        check("redo_last", {31'd0, q_a[0][19][8]}, 32'd1);
        check("redo_b19", {24'd0, q_a[0][19][7:0]}, {24'd0, dg[27]});
        check("drop_cnt0_hold", a_drop[0], 32'd1);
        clear_queues();

        // Length 40 but last on byte 30
        l0 = lerr_a;
        send_dgram(1'b0, 16'd10000, 16'd40, 30, 1'b1);
        wait_cycles(6);
        check("short_count", q_a[2].size(), 32'd22);
        check("short_last", {31'd0, q_a[2][21][8]}, 32'd1);
        check("short_notlast", {31'd0, q_a[2][20][8]}, 32'd0);
        check("short_lerr", lerr_a - l0, 32'd1);
        clear_queues();

        // Header forwarded: 12 bytes out, 1 MATCH + 8 emit stall cycles
        stall_b = 0; l0 = lerr_b;
        send_dgram(1'b1, 16'd20000, 16'd12, 12, 1'b1);
        wait_cycles(6);
        check("hdr_count", q_b[1].size(), 32'd12);
        for (int k = 0; k < 12; k++)
            check("hdr_entry", {23'd0, q_b[1][k]}, {23'd0, (k == 11), dg[k]});
        check("hdr_stall", stall_b, 32'd9);
        check("hdr_lerr", lerr_b - l0, 32'd0);
        clear_queues();

        // Reset mid-payload
        send_dgram(1'b0, 16'd20000, 16'd72, 18, 1'b0);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("mid_rst_vld", {28'd0, a_pvld}, 32'd0);
        check("mid_rst_last", {28'd0, a_plast}, 32'd0);
        check("mid_rst_rd", {31'd0, a_rd}, 32'd0);
        check("mid_rst_drop", a_drop[0], 32'd0);
        check("mid_rst_pulse", {30'd0, a_unsup, a_lerr}, 32'd0);
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);
        clear_queues();
        l0 = lerr_a;
        send_dgram(1'b0, 16'd20000, 16'd16, 16, 1'b1);
        wait_cycles(6);
        check("post_rst_count", q_a[1].size(), 32'd8);
        check("post_rst_last", {31'd0, q_a[1][7][8]}, 32'd1);
        check("post_rst_b0", {24'd0, q_a[1][0][7:0]}, {24'd0, dg[8]});
        check("post_rst_others", q_a[0].size() + q_a[2].size() + q_a[3].size(), 32'd0);
        check("post_rst_lerr", lerr_a - l0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
